// File: rtl/sys_dma_pkg.sv
// Shared constants, register map and state type for the ibus DMA engine.
// Imported by the register file and the DMA top.
package sys_dma_pkg;

  localparam int ADR_W = 18;
  localparam int DAT_W = 16;
  localparam int LEN_W = 16;

  localparam logic [13:0] OFF_SRC    = 14'd0;
  localparam logic [13:0] OFF_DST    = 14'd1;
  localparam logic [13:0] OFF_LEN    = 14'd2;
  localparam logic [13:0] OFF_CTRL   = 14'd3;
  localparam logic [13:0] OFF_STATUS = 14'd4;

  localparam int CTRL_START = 0;
  localparam int CTRL_DIR   = 1;
  localparam int CTRL_ABORT = 2;
  localparam int CTRL_IE    = 3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ABORTED = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic logic [ADR_W-1:0] adr_inc(
    input logic [ADR_W-1:0] a
  );
    return a + ADR_W'(1);
  endfunction

endpackage

// File: rtl/sys_dma_regs.sv
// DMA register file: SRC/DST/LEN/CTRL storage, START/ABORT pulses,
// STATUS read-back and pass-through of the upstream read chain.
module sys_dma_regs
  import sys_dma_pkg::*;
#(
  parameter logic [13:0] REG_BASE = 14'h0100
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [13:0]      wadr_i,
  input  logic [31:0]      wdata_i,
  input  logic [13:0]      radr_i,
  input  logic [31:0]      rdata_in_i,
  input  logic             busy_i,
  input  logic             done_i,
  input  logic             aborted_i,
  input  logic [LEN_W-1:0] remaining_i,
  output logic [31:0]      rdata_o,
  output logic [ADR_W-1:0] src_o,
  output logic [ADR_W-1:0] dst_o,
  output logic [LEN_W-1:0] len_o,
  output logic             dir_o,
  output logic             ie_o,
  output logic             start_o,
  output logic             abort_o
);

  logic [ADR_W-1:0] src_q;
  logic [ADR_W-1:0] dst_q;
  logic [LEN_W-1:0] len_q;
  logic             dir_q;
  logic             ie_q;
  logic [13:0]      woff;
  logic [13:0]      roff;
  logic             ctrl_wr;
  logic             unused_wdata;

  assign woff    = wadr_i - REG_BASE;
  assign roff    = radr_i - REG_BASE;
  assign ctrl_wr = we_i && (woff == OFF_CTRL);

  assign unused_wdata = ^wdata_i[31:ADR_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      dir_q <= 1'b0;
      ie_q  <= 1'b0;
    end else if (we_i) begin
      case (woff)
        OFF_SRC: src_q <= wdata_i[ADR_W-1:0];
        OFF_DST: dst_q <= wdata_i[ADR_W-1:0];
        OFF_LEN: len_q <= wdata_i[LEN_W-1:0];
        OFF_CTRL: begin
          dir_q <= wdata_i[CTRL_DIR];
          ie_q  <= wdata_i[CTRL_IE];
        end
        default: ;
      endcase
    end
  end

  assign start_o = ctrl_wr && wdata_i[CTRL_START];
  assign abort_o = ctrl_wr && wdata_i[CTRL_ABORT];

  // DIR written together with START must take effect for that transfer.
  assign dir_o = ctrl_wr ? wdata_i[CTRL_DIR] : dir_q;
  assign src_o = src_q;
  assign dst_o = dst_q;
  assign len_o = len_q;
  assign ie_o  = ie_q;

  always_comb begin
    rdata_o = rdata_in_i;
    case (roff)
      OFF_SRC:    rdata_o = {14'b0, src_q};
      OFF_DST:    rdata_o = {14'b0, dst_q};
      OFF_LEN:    rdata_o = {16'b0, len_q};
      OFF_CTRL:   rdata_o = {28'b0, ie_q, 1'b0, dir_q, 1'b0};
      OFF_STATUS: rdata_o = {remaining_i, 13'b0,
                             aborted_i, done_i, busy_i};
      default:    rdata_o = rdata_in_i;
    endcase
  end

endmodule

// File: rtl/sys_ibus_dma.sv
// Bus-master DMA between system memory and the systolic array ibus port.
// One read per cycle, each read's data written to the far side next cycle.
module sys_ibus_dma
  import sys_dma_pkg::*;
#(
  parameter logic [13:0] REG_BASE = 14'h0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic [31:0] dma_io_rdata_in,
  output logic [31:0] dma_io_rdata,
  output logic        ibus_ren,
  output logic [17:0] ibus_radr,
  input  logic [15:0] ibus_rdata,
  output logic        ibus_wen,
  output logic [17:0] ibus_wadr,
  output logic [15:0] ibus_wdata,
  output logic        mem_ren,
  output logic [17:0] mem_radr,
  input  logic [15:0] mem_rdata,
  output logic        mem_wen,
  output logic [17:0] mem_wadr,
  output logic [15:0] mem_wdata,
  output logic        irq
);

  logic [ADR_W-1:0] reg_src;
  logic [ADR_W-1:0] reg_dst;
  logic [LEN_W-1:0] reg_len;
  logic             reg_dir;
  logic             reg_ie;
  logic             start;
  logic             abort;

  state_e           state_q;
  logic             ren_q;
  logic             wen_q;
  logic             dir_q;
  logic             abort_q;
  logic             done_q;
  logic             aborted_q;
  logic [ADR_W-1:0] radr_q;
  logic [ADR_W-1:0] wadr_q;
  logic [LEN_W-1:0] rd_left_q;
  logic [LEN_W-1:0] rem_q;
  logic             busy;

  assign busy = (state_q != IDLE);

  sys_dma_regs #(
    .REG_BASE (REG_BASE)
  ) u_regs (
    .clk_i       (clk),
    .rst_i       (rst),
    .we_i        (dma_io_we),
    .wadr_i      (dma_io_wadr),
    .wdata_i     (dma_io_wdata),
    .radr_i      (dma_io_radr),
    .rdata_in_i  (dma_io_rdata_in),
    .busy_i      (busy),
    .done_i      (done_q),
    .aborted_i   (aborted_q),
    .remaining_i (rem_q),
    .rdata_o     (dma_io_rdata),
    .src_o       (reg_src),
    .dst_o       (reg_dst),
    .len_o       (reg_len),
    .dir_o       (reg_dir),
    .ie_o        (reg_ie),
    .start_o     (start),
    .abort_o     (abort)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ren_q     <= 1'b0;
      wen_q     <= 1'b0;
      dir_q     <= 1'b0;
      abort_q   <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      radr_q    <= '0;
      wadr_q    <= '0;
      rd_left_q <= '0;
      rem_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && !abort) begin
            done_q    <= (reg_len == '0);
            aborted_q <= 1'b0;
            abort_q   <= 1'b0;
            rem_q     <= reg_len;
            dir_q     <= reg_dir;
            if (reg_len != '0) begin
              state_q   <= RUN;
              ren_q     <= 1'b1;
              radr_q    <= reg_src;
              wadr_q    <= reg_dst;
              rd_left_q <= reg_len - LEN_W'(1);
            end
          end
        end
        RUN: begin
          // Every RUN cycle issues a read, so a write always follows.
          wen_q <= 1'b1;
          if (wen_q) begin
            wadr_q <= adr_inc(wadr_q);
            rem_q  <= rem_q - LEN_W'(1);
          end
          if (abort || (rd_left_q == '0)) begin
            ren_q   <= 1'b0;
            abort_q <= abort;
            state_q <= DRAIN;
          end else begin
            radr_q    <= adr_inc(radr_q);
            rd_left_q <= rd_left_q - LEN_W'(1);
          end
        end
        DRAIN: begin
          wen_q     <= 1'b0;
          rem_q     <= rem_q - LEN_W'(1);
          done_q    <= !(abort_q || abort);
          aborted_q <= abort_q || abort;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_ren    = ren_q & ~dir_q;
  assign mem_radr   = dir_q ? '0 : radr_q;
  assign ibus_ren   = ren_q & dir_q;
  assign ibus_radr  = dir_q ? radr_q : '0;

  assign ibus_wen   = wen_q & ~dir_q;
  assign ibus_wadr  = dir_q ? '0 : wadr_q;
  assign ibus_wdata = ibus_wen ? mem_rdata : '0;
  assign mem_wen    = wen_q & dir_q;
  assign mem_wadr   = dir_q ? wadr_q : '0;
  assign mem_wdata  = mem_wen ? ibus_rdata : '0;

  assign irq = done_q & reg_ie;

endmodule
